// File: rtl/lf_spi_cmd_rx.sv
// rtl/lf_spi_cmd_rx.sv - SPI command receiver with configuration, divisor and threshold registers
module lf_spi_cmd_rx #(
  parameter logic [7:0] DEFAULT_DIVISOR   = 8'd95,
  parameter logic [7:0] DEFAULT_THRESHOLD = 8'd127
) (
  input  logic       pck0,
  input  logic       reset,
  input  logic       spck,
  input  logic       mosi,
  input  logic       ncs,
  output logic       miso,
  output logic [8:0] conf_word,
  output logic [7:0] divisor,
  output logic [7:0] user_byte1,
  output logic       cmd_strobe,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    DECODE    = 2'd3
  } state_t;

  localparam logic [3:0] OP_CONF    = 4'b0001;
  localparam logic [3:0] OP_DIVISOR = 4'b0010;
  localparam logic [3:0] OP_USER1   = 4'b0011;

  // stage 1/2 resolve metastability, stage 3 is the previous value for edge detection
  logic spck_s1, spck_s2, spck_s3;
  logic mosi_s1, mosi_s2, mosi_s3;
  logic ncs_s1,  ncs_s2,  ncs_s3;

  logic spck_rise, spck_fall, ncs_rise, ncs_fall;

  state_t      state, state_nxt;
  logic [15:0] shift_reg, shift_nxt;
  logic [15:0] tx_reg, tx_nxt;
  logic [4:0]  bit_cnt, cnt_nxt;
  logic [8:0]  conf_nxt;
  logic [7:0]  div_nxt;
  logic [7:0]  ub1_nxt;
  logic        strobe_nxt;
  logic        err_nxt;
  logic        miso_nxt;

  // Bring the asynchronous SPI pins into the pck0 domain.
  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      {spck_s3, spck_s2, spck_s1} <= 3'b000;
      {mosi_s3, mosi_s2, mosi_s1} <= 3'b000;
      {ncs_s3,  ncs_s2,  ncs_s1}  <= 3'b000;
    end else begin
      {spck_s3, spck_s2, spck_s1} <= {spck_s2, spck_s1, spck};
      {mosi_s3, mosi_s2, mosi_s1} <= {mosi_s2, mosi_s1, mosi};
      {ncs_s3,  ncs_s2,  ncs_s1}  <= {ncs_s2,  ncs_s1,  ncs};
    end
  end

  assign spck_rise = spck_s2 & ~spck_s3;
  assign spck_fall = ~spck_s2 & spck_s3;
  assign ncs_rise  = ncs_s2 & ~ncs_s3;
  assign ncs_fall  = ~ncs_s2 & ncs_s3;

  // Frame sequencing, shifting and command decode; everything lands in registers below.
  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_reg;
    tx_nxt     = tx_reg;
    cnt_nxt    = bit_cnt;
    conf_nxt   = conf_word;
    div_nxt    = divisor;
    ub1_nxt    = user_byte1;
    strobe_nxt = 1'b0;
    err_nxt    = 1'b0;

    case (state)
      // A frame cut by reset is abandoned until ncs is seen idle again.
      WAIT_IDLE: begin
        if (ncs_s2) begin
          state_nxt = IDLE;
        end
      end

      IDLE: begin
        if (ncs_fall) begin
          state_nxt = SHIFT;
          shift_nxt = 16'd0;
          cnt_nxt   = 5'd0;
          tx_nxt    = {7'b0, conf_word};
        end
      end

      // End of frame wins over a coincident spck edge.
      SHIFT: begin
        if (ncs_rise) begin
          state_nxt = DECODE;
        end else begin
          if (spck_rise) begin
            shift_nxt = {shift_reg[14:0], mosi_s3};
            if (bit_cnt != 5'd31) begin
              cnt_nxt = bit_cnt + 5'd1;
            end
          end
          if (spck_fall) begin
            tx_nxt = {tx_reg[14:0], 1'b0};
          end
        end
      end

      DECODE: begin
        state_nxt = IDLE;
        if (bit_cnt == 5'd16) begin
          case (shift_reg[15:12])
            OP_CONF: begin
              conf_nxt   = shift_reg[8:0];
              strobe_nxt = 1'b1;
              if (shift_reg[8:0] == 9'b000000001) begin
                ub1_nxt = DEFAULT_THRESHOLD;
              end
            end
            OP_DIVISOR: begin
              div_nxt    = shift_reg[7:0];
              strobe_nxt = 1'b1;
            end
            OP_USER1: begin
              ub1_nxt    = shift_reg[7:0];
              strobe_nxt = 1'b1;
            end
            default: begin
            end
          endcase
        end else begin
          err_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt = WAIT_IDLE;
      end
    endcase

    miso_nxt = (state_nxt == SHIFT) ? tx_nxt[15] : 1'b0;
  end

  // State, datapath and output registers.
  always_ff @(posedge pck0 or posedge reset) begin
    if (reset) begin
      state      <= WAIT_IDLE;
      shift_reg  <= 16'd0;
      tx_reg     <= 16'd0;
      bit_cnt    <= 5'd0;
      conf_word  <= 9'd0;
      divisor    <= DEFAULT_DIVISOR;
      user_byte1 <= 8'd0;
      cmd_strobe <= 1'b0;
      frame_err  <= 1'b0;
      miso       <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift_reg  <= shift_nxt;
      tx_reg     <= tx_nxt;
      bit_cnt    <= cnt_nxt;
      conf_word  <= conf_nxt;
      divisor    <= div_nxt;
      user_byte1 <= ub1_nxt;
      cmd_strobe <= strobe_nxt;
      frame_err  <= err_nxt;
      miso       <= miso_nxt;
    end
  end

endmodule

// File: doc/lf_spi_cmd_rx.md
LF_SPI_CMD_RX -- requirements
Module: lf_spi_cmd_rx

Interface
REQ-001 SHALL have parameter DEFAULT_DIVISOR, default 8'd95, giving the divisor value after reset.
REQ-002 SHALL have parameter DEFAULT_THRESHOLD, default 8'd127, giving the user_byte1 value loaded on the edge-detect configuration write.
REQ-003 SHALL have port pck0, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port spck, input, 1 bit: SPI clock from the ARM, asynchronous to pck0.
REQ-006 SHALL have port mosi, input, 1 bit: SPI data in, MSB first.
REQ-007 SHALL have port ncs, input, 1 bit: SPI chip select, active low.
REQ-008 SHALL have port miso, output, 1 bit: SPI readback data.
REQ-009 SHALL have port conf_word, output, 9 bits: configuration register; bits [8:6] are major_mode.
REQ-010 SHALL have port divisor, output, 8 bits: clock divisor register.
REQ-011 SHALL have port user_byte1, output, 8 bits: user parameter, the edge-detect threshold.
REQ-012 SHALL have port cmd_strobe, output, 1 bit: one-cycle pulse when a valid command has updated a register.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse when a frame is discarded.

Function
REQ-014 SHALL pass spck, mosi and ncs through two-flop synchronizers, then one further register used for edge detection.
REQ-015 SHALL detect an spck rise, an spck fall, an ncs fall and an ncs rise from synchronized stage 2 versus stage 3; each edge is detected exactly 3 pck0 cycles after the pin edge, or 2 cycles with best-case alignment.
REQ-016 SHALL implement the states WAIT_IDLE, IDLE, SHIFT and DECODE.
REQ-017 SHALL move from WAIT_IDLE to IDLE on the first cycle where synchronized ncs is high; no shifting occurs in WAIT_IDLE.
REQ-018 SHALL, on an ncs fall in IDLE: enter SHIFT; clear the 16-bit shift register; clear the 5-bit bit counter; load the 16-bit tx register with {7'b0, conf_word}.
REQ-019 SHALL, in SHIFT on each spck rise: shift the shift register left; take synchronized mosi into bit 0; increment the bit counter, saturating at 31.
REQ-020 SHALL, in SHIFT on each spck fall: shift the tx register left with zero fill; miso always equals tx register bit 15.
REQ-021 SHALL, on an ncs rise in SHIFT, enter DECODE for exactly one cycle and then return to IDLE.
REQ-022 SHALL, in the same cycle, give the ncs rise priority over any spck edge; that spck edge is ignored.
REQ-023 SHALL, in DECODE with bit counter == 16 and shift[15:12] == 4'b0001, load conf_word <= shift[8:0].
REQ-024 SHALL also load user_byte1 <= DEFAULT_THRESHOLD in that decode when shift[8:0] == 9'b000000001.
REQ-025 SHALL, in DECODE with bit counter == 16 and shift[15:12] == 4'b0010, load divisor <= shift[7:0].
REQ-026 SHALL, in DECODE with bit counter == 16 and shift[15:12] == 4'b0011, load user_byte1 <= shift[7:0].
REQ-027 SHALL make register updates visible on the clock edge that leaves DECODE, with cmd_strobe high for that same single cycle.
REQ-028 SHALL, in DECODE with bit counter == 16 and any other opcode, change no register and assert neither cmd_strobe nor frame_err.
REQ-029 SHALL, in DECODE with bit counter != 16 (short, long or empty frame), change no register and pulse frame_err for one cycle.
REQ-030 SHALL ignore spck edges in IDLE and WAIT_IDLE.
REQ-031 SHALL hold miso at 0 outside SHIFT.
REQ-032 SHALL register all outputs, with no combinational path from input pins to outputs.

Reset
REQ-033 SHALL, while reset is high, force: conf_word = 9'd0, divisor = DEFAULT_DIVISOR, user_byte1 = 8'd0, miso = 0, cmd_strobe = 0, frame_err = 0, counters and shift registers = 0, synchronizers = 0.
REQ-034 SHALL enter WAIT_IDLE on reset, so a frame in progress at reset release is discarded silently (no frame_err) and the next ncs fall starts a fresh frame.

Verification
REQ-035 SHALL cover: frame 0x1001 with slow spck (>= 8 pck0 per phase) -> conf_word = 9'h001, user_byte1 = 127, one cmd_strobe pulse.
REQ-036 SHALL cover: frame 0x20A5, then 0x3042 -> divisor = 0xA5, user_byte1 = 0x42, two cmd_strobe pulses, conf_word unchanged.
REQ-037 SHALL cover: 15-bit and 17-bit frames of opcode 0x2 -> divisor stays 95, frame_err pulses twice, no cmd_strobe.
REQ-038 SHALL cover: conf_word = 9'h081, then a frame started -> miso bits on successive spck rises read 0x0081 MSB first.
REQ-039 SHALL cover: reset asserted after 8 bits with ncs held low, released, ncs raised, then 0x2010 sent -> no frame_err, divisor = 0x10.
REQ-040 SHALL cover: opcode 0x7 frame -> no register change, no strobe, no frame_err.
